// File: rtl/data_mem_mmio.sv
// data_mem_mmio
//   Data-side memory subsystem for a single-cycle core: word-addressed RAM,
//   a memory-mapped console transmit FIFO, and (optionally) a free-running
//   cycle counter with a one-shot compare timer.
//
//   Optional feature macro: DMEM_TIMER_EN
//     defined   -> CYCLE (0x08), TIMER_CMP (0x0C), TIMER_CTRL (0x10) and
//                  timer_irq are built.
//     undefined -> those offsets read 0 and ignore writes; STATUS.tpend
//                  reads 0; timer_irq is tied low.
//
// Ports
//   clk            in   single clock, all state on rising edge
//   reset          in   synchronous, active-high
//   WE             in   store strobe from core
//   address_to_mem in   byte address (bits [1:0] ignored)
//   data_to_mem    in   store data
//   data_from_mem  out  load data, combinational in the same cycle
//   con_data       out  console FIFO head byte (0 when empty)
//   con_valid      out  console FIFO non-empty
//   con_ready      in   sink accepts the head byte this cycle
//   timer_irq      out  registered timer interrupt
//
// MMIO map (byte offset from MMIO_BASE, 256-byte window)
//   0x00 CON_TX (WO)  0x04 STATUS {tpend,err,ovf,full,empty}, W1C on ovf/err
//   0x08 CYCLE        0x0C TIMER_CMP      0x10 TIMER_CTRL {clr_tpend(W), ie}
module data_mem_mmio #(
  parameter int unsigned MEM_WORDS  = 256,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [31:0] address_to_mem,
  input  logic [31:0] data_to_mem,
  output logic [31:0] data_from_mem,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic        timer_irq
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);

  localparam logic [5:0] OFF_CON_TX = 6'h00;
  localparam logic [5:0] OFF_STATUS = 6'h01;
  localparam logic [5:0] OFF_CYCLE  = 6'h02;
  localparam logic [5:0] OFF_CMP    = 6'h03;
  localparam logic [5:0] OFF_CTRL   = 6'h04;

  // ---------------------------------------------------------------- decode
  logic          ram_hit, mmio_hit, unmapped;
  logic [5:0]    reg_off;
  logic [AW-1:0] ram_idx;
  logic          wr_con, wr_status;
  logic          unused_addr_bits;

  assign ram_hit   = (address_to_mem[31:AW+2] == '0);
  assign mmio_hit  = !ram_hit && (address_to_mem[31:8] == MMIO_BASE[31:8]);
  assign unmapped  = !ram_hit && !mmio_hit;
  assign reg_off   = address_to_mem[7:2];
  assign ram_idx   = address_to_mem[AW+1:2];
  assign wr_con    = WE && mmio_hit && (reg_off == OFF_CON_TX);
  assign wr_status = WE && mmio_hit && (reg_off == OFF_STATUS);
  // All accesses are word-sized; the byte lane bits carry no information.
  assign unused_addr_bits = ^address_to_mem[1:0];

  // ---------------------------------------------------------------- storage
  logic [31:0]   ram      [MEM_WORDS];
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  logic          full, empty, pop, push;
  logic          ovf, err, tpend;

  assign empty     = (count == '0);
  assign full      = (count == DEPTH);
  assign con_valid = !empty;
  assign con_data  = empty ? 8'h00 : fifo_mem[head];
  assign pop       = con_valid && con_ready;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push      = wr_con && (!full || pop);

  // NOTE: storage arrays have no reset term, so a reset only blocks the
  // write; contents survive reset and stay as plain RAM, not flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (WE && ram_hit) ram[ram_idx] <= data_to_mem;
      if (push)          fifo_mem[tail] <= data_to_mem[7:0];
    end
  end

  // NOTE: every register in clocked blocks is updated with <= so all reads
  // in the same edge see pre-edge values, matching single-cycle commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (pop)  head <= head + 1'b1;
      if (push) tail <= tail + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);

      if (wr_con && full && !pop)          ovf <= 1'b1;
      else if (wr_status && data_to_mem[2]) ovf <= 1'b0;

      if (WE && unmapped)                  err <= 1'b1;
      else if (wr_status && data_to_mem[3]) err <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- timer
  logic [31:0] cycle_rd, cmp_rd, ctrl_rd;

`ifdef DMEM_TIMER_EN
  logic [31:0] cycle_cnt, cmp;
  logic        armed, ie, match, tpend_next, ie_next;
  logic        wr_cycle, wr_cmp, wr_ctrl;

  assign wr_cycle   = WE && mmio_hit && (reg_off == OFF_CYCLE);
  assign wr_cmp     = WE && mmio_hit && (reg_off == OFF_CMP);
  assign wr_ctrl    = WE && mmio_hit && (reg_off == OFF_CTRL);
  assign match      = armed && (cycle_cnt == cmp);
  assign ie_next    = wr_ctrl ? data_to_mem[0] : ie;
  // A new match wins over a software clear in the same cycle.
  assign tpend_next = match || (tpend && !(wr_ctrl && data_to_mem[1]));

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      cmp       <= '1;
      armed     <= 1'b0;
      tpend     <= 1'b0;
      ie        <= 1'b0;
      timer_irq <= 1'b0;
    end else begin
      cycle_cnt <= wr_cycle ? data_to_mem : cycle_cnt + 32'd1;
      if (wr_cmp) begin
        cmp   <= data_to_mem;
        armed <= 1'b1;
      end else if (match) begin
        armed <= 1'b0;   // one-shot: re-armed only by a CMP write
      end
      tpend     <= tpend_next;
      ie        <= ie_next;
      timer_irq <= tpend_next && ie_next;
    end
  end

  assign cycle_rd = cycle_cnt;
  assign cmp_rd   = cmp;
  assign ctrl_rd  = {31'b0, ie};
`else
  assign tpend     = 1'b0;
  assign timer_irq = 1'b0;
  assign cycle_rd  = '0;
  assign cmp_rd    = '0;
  assign ctrl_rd   = '0;
`endif

  // ---------------------------------------------------------------- read mux
  // NOTE: the default assignment up front keeps this block purely
  // combinational for every address path.
  always_comb begin
    data_from_mem = '0;
    if (ram_hit) begin
      data_from_mem = ram[ram_idx];
    end else if (mmio_hit) begin
      case (reg_off)
        OFF_STATUS: data_from_mem = {27'b0, tpend, err, ovf, full, empty};
        OFF_CYCLE:  data_from_mem = cycle_rd;
        OFF_CMP:    data_from_mem = cmp_rd;
        OFF_CTRL:   data_from_mem = ctrl_rd;
        default:    data_from_mem = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
module tb_data_mem_mmio;
  localparam logic [31:0] MMIO = 32'hFFFF0000;

  logic        clk = 1'b0;
  logic        reset, WE, con_ready, con_valid, timer_irq;
  logic [31:0] address_to_mem, data_to_mem, data_from_mem;
  logic [7:0]  con_data;

  int checks = 0;
  int errors = 0;

  data_mem_mmio dut (
    .clk(clk), .reset(reset), .WE(WE),
    .address_to_mem(address_to_mem), .data_to_mem(data_to_mem),
    .data_from_mem(data_from_mem), .con_data(con_data),
    .con_valid(con_valid), .con_ready(con_ready), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------ reference model
  logic [31:0] m_mem [256];
  logic [7:0]  m_q [$];
  logic        m_ovf, m_err, m_tpend, m_ie, m_armed, m_irq;
  logic [31:0] m_cycle, m_cmp;

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0; m_err = 0; m_tpend = 0; m_ie = 0; m_armed = 0; m_irq = 0;
    m_cycle = 0; m_cmp = 32'hFFFFFFFF;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a < 32'd1024) return m_mem[a[9:2]];
    if (a[31:8] == 24'hFFFF00) begin
      case (a[7:2])
        6'd1: return {27'b0, m_tpend, m_err, m_ovf, (m_q.size() == 8), (m_q.size() == 0)};
`ifdef DMEM_TIMER_EN
        6'd2: return m_cycle;
        6'd3: return m_cmp;
        6'd4: return {31'b0, m_ie};
`endif
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] d,
                            input logic rdy);
    int n;
    logic pop, is_mmio;
    logic [5:0] off;
`ifdef DMEM_TIMER_EN
    logic match;
`endif
    n = m_q.size();
    pop = (n != 0) && rdy;
    is_mmio = (a >= 32'd1024) && (a[31:8] == 24'hFFFF00);
    off = a[7:2];
`ifdef DMEM_TIMER_EN
    match = m_armed && (m_cycle == m_cmp);
    m_cycle = (we && is_mmio && off == 6'd2) ? d : m_cycle + 32'd1;
    if (we && is_mmio && off == 6'd3) begin m_cmp = d; m_armed = 1; end
    else if (match) m_armed = 0;
    if (match) m_tpend = 1;
    else if (we && is_mmio && off == 6'd4 && d[1]) m_tpend = 0;
    if (we && is_mmio && off == 6'd4) m_ie = d[0];
    m_irq = m_tpend & m_ie;
`endif
    if (pop) void'(m_q.pop_front());
    if (we) begin
      if (a < 32'd1024) m_mem[a[9:2]] = d;
      else if (is_mmio) begin
        if (off == 6'd0) begin
          if (n < 8 || pop) m_q.push_back(d[7:0]);
          else m_ovf = 1;
        end else if (off == 6'd1) begin
          if (d[2]) m_ovf = 0;
          if (d[3]) m_err = 0;
        end
      end else m_err = 1;
    end
  endtask

  // One core cycle: drive, sample outputs before the edge, update model after.
  logic [31:0] rd;
  logic        cv, irq;
  logic [7:0]  cd;

  task automatic cyc(input logic rst, input logic we, input logic [31:0] a,
                     input logic [31:0] d, input logic rdy,
                     output logic [31:0] rd_o, output logic cv_o,
                     output logic [7:0] cd_o, output logic irq_o);
    reset = rst; WE = we; address_to_mem = a; data_to_mem = d; con_ready = rdy;
    #1;
    rd_o = data_from_mem; cv_o = con_valid; cd_o = con_data; irq_o = timer_irq;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(we, a, d, rdy);
    @(negedge clk);
  endtask

  // ------------------------------------------------ tests
  task automatic test_reset();
    cyc(1, 0, 0, 0, 0, rd, cv, cd, irq);
    cyc(1, 1, MMIO, 32'h55, 0, rd, cv, cd, irq);
    cyc(0, 0, MMIO + 4, 0, 0, rd, cv, cd, irq);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL reset_status: got %h expected %h", rd, 32'h1); end
    checks++; if (cv !== 1'b0 || cd !== 8'h00) begin errors++; $display("FAIL reset_con: got v=%b d=%h expected v=0 d=00", cv, cd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    cyc(0, 0, MMIO + 8, 0, 0, rd, cv, cd, irq);
`ifdef DMEM_TIMER_EN
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL reset_cycle: got %h expected %h", rd, 32'd1); end
    cyc(0, 0, MMIO + 12, 0, 0, rd, cv, cd, irq);
    checks++; if (rd !== 32'hFFFFFFFF) begin errors++; $display("FAIL reset_cmp: got %h expected ffffffff", rd); end
`else
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_cycle: got %h expected 0", rd); end
`endif
  endtask

  task automatic test_ram();
    cyc(0, 1, 32'h40, 32'hDEADBEEF, 0, rd, cv, cd, irq);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ram_rdw_old: got %h expected 0", rd); end
    cyc(0, 0, 32'h40, 0, 0, rd, cv, cd, irq);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_rd40: got %h expected deadbeef", rd); end
    cyc(0, 1, 32'h3FC, 32'h12345678, 0, rd, cv, cd, irq);
    cyc(0, 0, 32'h43, 0, 0, rd, cv, cd, irq);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_rd43: got %h expected deadbeef", rd); end
    cyc(0, 0, 32'h3FF, 0, 0, rd, cv, cd, irq);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL ram_last_word: got %h expected 12345678", rd); end
  endtask

  task automatic test_fifo_overflow();
    for (int i = 0; i < 9; i++) begin
      cyc(0, 1, MMIO, 32'h41 + i, 0, rd, cv, cd, irq);
      if (i == 0) begin
        checks++; if (cv !== 1'b0) begin errors++; $display("FAIL fifo_no_bypass: got v=%b expected 0", cv); end
      end
      if (i == 1) begin
        checks++; if (cv !== 1'b1 || cd !== 8'h41) begin errors++; $display("FAIL fifo_first: got v=%b d=%h expected v=1 d=41", cv, cd); end
      end
    end
    cyc(0, 0, MMIO + 4, 0, 0, rd, cv, cd, irq);
    checks++; if (rd !== 32'h6) begin errors++; $display("FAIL fifo_ovf_status: got %h expected 6", rd); end
    checks++; if (cd !== 8'h41) begin errors++; $display("FAIL fifo_head: got %h expected 41", cd); end
    cyc(0, 1, MMIO + 4, 32'h4, 0, rd, cv, cd, irq);
    cyc(0, 0, MMIO + 4, 0, 0, rd, cv, cd, irq);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL fifo_ovf_clear: got %h expected 2", rd); end
  endtask

  task automatic test_fifo_full_pop();
    logic [7:0] exp_bytes [8];
    for (int i = 0; i < 7; i++) exp_bytes[i] = 8'h42 + 8'(i);
    exp_bytes[7] = 8'h5A;
    cyc(0, 1, MMIO, 32'h5A, 1, rd, cv, cd, irq);
    checks++; if (cd !== 8'h41) begin errors++; $display("FAIL full_pop_head: got %h expected 41", cd); end
    cyc(0, 0, MMIO + 4, 0, 0, rd, cv, cd, irq);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL full_pop_status: got %h expected 2", rd); end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, MMIO + 4, 0, 1, rd, cv, cd, irq);
      checks++; if (cv !== 1'b1 || cd !== exp_bytes[i]) begin errors++; $display("FAIL drain_%0d: got v=%b d=%h expected v=1 d=%h", i, cv, cd, exp_bytes[i]); end
    end
    cyc(0, 0, MMIO + 4, 0, 0, rd, cv, cd, irq);
    checks++; if (rd !== 32'h1 || cv !== 1'b0 || cd !== 8'h00) begin errors++; $display("FAIL drain_empty: got st=%h v=%b d=%h expected st=1 v=0 d=00", rd, cv, cd); end
  endtask

  task automatic test_err_and_reset();
    cyc(0, 1, 32'h80000000, 32'h1234, 0, rd, cv, cd, irq);
    cyc(0, 0, 32'h80000000, 0, 0, rd, cv, cd, irq);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected 0", rd); end
    cyc(0, 0, MMIO + 4, 0, 0, rd, cv, cd, irq);
    checks++; if (rd !== 32'h9) begin errors++; $display("FAIL err_set: got %h expected 9", rd); end
    cyc(0, 1, MMIO + 4, 32'h8, 0, rd, cv, cd, irq);
    cyc(0, 1, MMIO + 32'h20, 32'hFF, 0, rd, cv, cd, irq);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL undecoded_read: got %h expected 0", rd); end
    cyc(0, 0, MMIO + 4, 0, 0, rd, cv, cd, irq);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL err_clear_no_set: got %h expected 1", rd); end
    cyc(0, 1, 32'h400, 32'h5, 0, rd, cv, cd, irq);
    cyc(0, 0, MMIO + 4, 0, 0, rd, cv, cd, irq);
    checks++; if (rd !== 32'h9) begin errors++; $display("FAIL ram_edge_err: got %h expected 9", rd); end
    cyc(0, 1, MMIO, 32'h77, 0, rd, cv, cd, irq);
    cyc(1, 1, 32'h40, 32'h0BADF00D, 0, rd, cv, cd, irq);
    checks++; if (cv !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b expected 1", cv); end
    cyc(0, 0, 32'h40, 0, 0, rd, cv, cd, irq);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_survives_reset: got %h expected deadbeef", rd); end
    checks++; if (cv !== 1'b0) begin errors++; $display("FAIL reset_clears_fifo: got %b expected 0", cv); end
    cyc(0, 0, MMIO + 4, 0, 0, rd, cv, cd, irq);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL reset_clears_err: got %h expected 1", rd); end
  endtask

`ifdef DMEM_TIMER_EN
  task automatic test_timer();
    cyc(0, 1, MMIO + 8,  32'd100, 0, rd, cv, cd, irq);
    cyc(0, 1, MMIO + 12, 32'd105, 0, rd, cv, cd, irq);
    cyc(0, 1, MMIO + 16, 32'd1,   0, rd, cv, cd, irq);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, MMIO + 8, 0, 0, rd, cv, cd, irq);
      checks++; if (rd !== 32'd102 + 32'(i) || irq !== 1'b0) begin errors++; $display("FAIL timer_count_%0d: got c=%0d irq=%b expected c=%0d irq=0", i, rd, irq, 102 + i); end
    end
    cyc(0, 0, MMIO + 4, 0, 0, rd, cv, cd, irq);
    checks++; if (rd !== 32'h11 || irq !== 1'b1) begin errors++; $display("FAIL timer_fire: got st=%h irq=%b expected st=11 irq=1", rd, irq); end
    cyc(0, 1, MMIO + 16, 32'h2, 0, rd, cv, cd, irq);
    cyc(0, 0, MMIO + 16, 0, 0, rd, cv, cd, irq);
    checks++; if (irq !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL timer_clear: got ctrl=%h irq=%b expected ctrl=0 irq=0", rd, irq); end
    cyc(0, 1, MMIO + 16, 32'h1, 0, rd, cv, cd, irq);
    cyc(0, 1, MMIO + 8, 32'hFFFFFFF0, 0, rd, cv, cd, irq);
    for (int i = 0; i < 130; i++) begin
      cyc(0, 0, MMIO + 4, 0, 0, rd, cv, cd, irq);
      checks++; if (rd !== 32'h1 || irq !== 1'b0) begin errors++; $display("FAIL timer_no_refire_%0d: got st=%h irq=%b expected st=1 irq=0", i, rd, irq); end
    end
  endtask
`else
  task automatic test_timer_absent();
    cyc(0, 1, MMIO + 8,  32'hFFFFFFFF, 0, rd, cv, cd, irq);
    cyc(0, 1, MMIO + 12, 32'h0, 0, rd, cv, cd, irq);
    cyc(0, 1, MMIO + 16, 32'h3, 0, rd, cv, cd, irq);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, MMIO + 8 + 32'(4 * i), 0, 0, rd, cv, cd, irq);
      checks++; if (rd !== 32'h0 || irq !== 1'b0) begin errors++; $display("FAIL no_timer_reg_%0d: got %h irq=%b expected 0 irq=0", i, rd, irq); end
    end
    cyc(0, 0, MMIO + 4, 0, 0, rd, cv, cd, irq);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL no_timer_status: got %h expected 1", rd); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] offs [7];
    logic [31:0] a, d, exp_rd;
    logic        we, rdy, rst, exp_cv, exp_irq;
    logic [7:0]  exp_cd;
    offs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h20};
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 32'($urandom_range(0, 1023));
        4, 5, 6, 7: a = MMIO | offs[$urandom_range(0, 6)] | 32'($urandom_range(0, 3));
        8:          a = 32'h1000 + 32'($urandom_range(0, 4095));
        default:    a = 32'h80000000 | 32'($urandom);
      endcase
      d   = $urandom;
      we  = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 63) == 0);
      exp_rd  = model_read(a);
      exp_cv  = (m_q.size() != 0);
      exp_cd  = exp_cv ? m_q[0] : 8'h00;
      exp_irq = m_irq;
      cyc(rst, we, a, d, rdy, rd, cv, cd, irq);
      checks++;
      if (rd !== exp_rd || cv !== exp_cv || cd !== exp_cd || irq !== exp_irq) begin
        errors++;
        $display("FAIL rand_%0d addr=%h: got rd=%h v=%b d=%h irq=%b expected rd=%h v=%b d=%h irq=%b",
                 i, a, rd, cv, cd, irq, exp_rd, exp_cv, exp_cd, exp_irq);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
    model_reset();
    test_reset();
    test_ram();
    test_fifo_overflow();
    test_fifo_full_pop();
    test_err_and_reset();
`ifdef DMEM_TIMER_EN
    test_timer();
`else
    test_timer_absent();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
